ad7606_pkt_parse: RTL and testbench

Byte-stream frame receiver that decodes the AD7606 sample frame format (0x55 preamble, command ID, payload length, then per-channel triplets of channel ID, data high byte, data low byte) back into per-channel 16-bit samples. It sits at the far end of the ADC data link: in the host-side loopback/verification path and in the board-to-board capture path, behind the UART/byte receiver. It validates framing, checks sequence and length, and reports frame completion or a coded error.

---
 rtl/ad7606_pkt_pkg.sv | 36 +++
 rtl/ad7606_pkt_parse.sv | 170 +++++++++++++++++
 tb/tb_ad7606_pkt_parse.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7606_pkt_pkg.sv
// Shared constants and types for the AD7606 sample-frame packetizer and parser.
// Both ends of the link import this so the frame format is defined once.
package ad7606_pkt_pkg;

    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] CMD_ADC  = 8'd5;
    localparam logic [7:0] TRIPLET  = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_CH_ID,
        ST_DATA_H,
        ST_DATA_L
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_CMD  = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_SEQ  = 3'd3;
    localparam logic [2:0] ERR_GAP  = 3'd4;

    // Legal lengths are 3, 6, ... 3*max_ch; matched against a constant list so no divider is built.
    function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_ch);
        logic ok;
        ok = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if ((len == 8'(3 * k)) && (8'(k) <= max_ch)) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/ad7606_pkt_parse.sv
// Byte-stream receiver for AD7606 sample frames: preamble, command, length, then
// (id, hi, lo) triplets. Emits per-channel samples and a done or coded-error pulse.
module ad7606_pkt_parse
    import ad7606_pkt_pkg::*;
#(
    parameter logic [7:0]  CMD_ID      = CMD_ADC,
    parameter logic [7:0]  MAX_CH      = 8'd8,
    parameter logic [15:0] GAP_TIMEOUT = 16'd5000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_ch_id,
    output logic [15:0] o_ch_data,
    output logic        o_ch_valid,
    output logic        o_frame_done,
    output logic [7:0]  o_ch_num,
    output logic        o_frame_err,
    output logic [2:0]  o_err_code
);

    // Handshake: a byte is consumed on every cycle i_rx_valid is high; there is no back-pressure.

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  exp_id_q, exp_id_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  ch_id_q, ch_id_d;
    logic [15:0] ch_data_q, ch_data_d;
    logic        ch_valid_q, ch_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  ch_num_q, ch_num_d;
    logic        frame_err_q, frame_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [7:0]  cnt_next;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        exp_id_d     = exp_id_q;
        hi_d         = hi_q;
        timer_d      = timer_q;
        ch_id_d      = ch_id_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        ch_num_d     = ch_num_q;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        cnt_next     = cnt_q + TRIPLET;

        if (i_rx_valid) begin
            timer_d = 16'd0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_data == PREAMBLE) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (i_rx_data == CMD_ID) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CMD;
                    end
                end
                ST_LEN: begin
                    if (len_legal(i_rx_data, MAX_CH)) begin
                        len_d    = i_rx_data;
                        cnt_d    = 8'd0;
                        exp_id_d = 8'd1;
                        state_d  = ST_CH_ID;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
                ST_CH_ID: begin
                    if (i_rx_data == exp_id_q) begin
                        state_d = ST_DATA_H;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_SEQ;
                    end
                end
                ST_DATA_H: begin
                    hi_d    = i_rx_data;
                    state_d = ST_DATA_L;
                end
                ST_DATA_L: begin
                    ch_valid_d = 1'b1;
                    ch_id_d    = exp_id_q;
                    ch_data_d  = {hi_q, i_rx_data};
                    cnt_d      = cnt_next;
                    // Expected ID equals the channel count once the last triplet lands.
                    if (cnt_next == len_q) begin
                        frame_done_d = 1'b1;
                        ch_num_d     = exp_id_q;
                        state_d      = ST_IDLE;
                    end else begin
                        exp_id_d = exp_id_q + 8'd1;
                        state_d  = ST_CH_ID;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q >= GAP_TIMEOUT) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_GAP;
            end else if (timer_q != 16'hFFFF) begin
                timer_d = timer_q + 16'd1;
            end
        end

        if (state_d == ST_IDLE) begin
            timer_d = 16'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            exp_id_q     <= 8'd0;
            hi_q         <= 8'd0;
            timer_q      <= 16'd0;
            ch_id_q      <= 8'd0;
            ch_data_q    <= 16'd0;
            ch_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ch_num_q     <= 8'd0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            exp_id_q     <= exp_id_d;
            hi_q         <= hi_d;
            timer_q      <= timer_d;
            ch_id_q      <= ch_id_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            ch_num_q     <= ch_num_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign o_ch_id      = ch_id_q;
    assign o_ch_data    = ch_data_q;
    assign o_ch_valid   = ch_valid_q;
    assign o_frame_done = frame_done_q;
    assign o_ch_num     = ch_num_q;
    assign o_frame_err  = frame_err_q;
    assign o_err_code   = err_code_q;

endmodule

// File: tb/tb_ad7606_pkt_parse.sv
// Directed bench for ad7606_pkt_parse: a frame-level decoder model builds the
// expected pulse sequence; a compare process checks every pulse cycle against it.
module tb_ad7606_pkt_parse;

    localparam int          CMD     = 5;
    localparam int          MAXCH   = 8;
    localparam logic [15:0] GAP     = 16'd5000;
    localparam int          TIMEOUT = -1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  o_ch_id;
    logic [15:0] o_ch_data;
    logic        o_ch_valid;
    logic        o_frame_done;
    logic [7:0]  o_ch_num;
    logic        o_frame_err;
    logic [2:0]  o_err_code;

    typedef struct packed {
        logic        smp;
        logic [7:0]  id;
        logic [15:0] data;
        logic        done;
        logic        err;
        logic [7:0]  num;
        logic [2:0]  code;
    } ev_t;

    ev_t exp_q[$];
    int  seg[$];
    int  m_num;
    int  m_code;
    int  vectors;
    int  miscompares;

    ad7606_pkt_parse #(
        .CMD_ID      (8'(CMD)),
        .MAX_CH      (8'(MAXCH)),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_ch_id      (o_ch_id),
        .o_ch_data    (o_ch_data),
        .o_ch_valid   (o_ch_valid),
        .o_frame_done (o_frame_done),
        .o_ch_num     (o_ch_num),
        .o_frame_err  (o_frame_err),
        .o_err_code   (o_err_code)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model
    task automatic push_ev(input logic smp, input int id, input int data, input logic done, input logic err);
        ev_t e;
        e.smp  = smp;
        e.id   = 8'(id);
        e.data = 16'(data);
        e.done = done;
        e.err  = err;
        e.num  = 8'(m_num);
        e.code = 3'(m_code);
        exp_q.push_back(e);
    endtask

    task automatic model_err(input int code);
        m_code = code;
        push_ev(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // Decodes the whole token list frame by frame; TIMEOUT marks a gap long enough to abort.
    task automatic model_run();
        int i;
        int len;
        int nch;
        int t[3];
        bit stop;
        i = 0;
        while (i < seg.size()) begin
            if (seg[i] != 'h55) begin
                i++;
                continue;
            end
            i++;
            if (i >= seg.size()) break;
            if (seg[i] == TIMEOUT) begin model_err(4); i++; continue; end
            if (seg[i] != CMD) begin model_err(1); i++; continue; end
            i++;
            if (i >= seg.size()) break;
            if (seg[i] == TIMEOUT) begin model_err(4); i++; continue; end
            len = seg[i];
            i++;
            if ((len % 3) != 0 || len < 3 || len > 3 * MAXCH) begin model_err(2); continue; end
            nch  = len / 3;
            stop = 1'b0;
            for (int k = 1; k <= nch && !stop; k++) begin
                for (int j = 0; j < 3 && !stop; j++) begin
                    if (i >= seg.size()) begin
                        stop = 1'b1;
                    end else if (seg[i] == TIMEOUT) begin
                        model_err(4);
                        i++;
                        stop = 1'b1;
                    end else if (j == 0 && seg[i] != k) begin
                        model_err(3);
                        i++;
                        stop = 1'b1;
                    end else begin
                        t[j] = seg[i];
                        i++;
                    end
                end
                if (!stop) begin
                    if (k == nch) m_num = nch;
                    push_ev(1'b1, k, t[1] * 256 + t[2], k == nch, 1'b0);
                end
            end
        end
    endtask

    // driver tasks
    task automatic send_byte(input int b);
        rx_data  = 8'(b);
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seg();
        foreach (seg[i]) begin
            if (seg[i] != TIMEOUT) send_byte(seg[i]);
        end
    endtask

    task automatic run_seg();
        model_run();
        send_seg();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ch_id"},      int'(o_ch_id), 0);
        chk({tag, "_ch_data"},    int'(o_ch_data), 0);
        chk({tag, "_ch_valid"},   int'(o_ch_valid), 0);
        chk({tag, "_frame_done"}, int'(o_frame_done), 0);
        chk({tag, "_ch_num"},     int'(o_ch_num), 0);
        chk({tag, "_frame_err"},  int'(o_frame_err), 0);
        chk({tag, "_err_code"},   int'(o_err_code), 0);
    endtask

    // scoreboard: every cycle with a pulse must match the next expected event
    always @(posedge clk) begin
        #1;
        if (rst_n && (o_ch_valid || o_frame_done || o_frame_err)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: valid=%0b done=%0b err=%0b id=%0d data=%h code=%0d, required no pulse",
                         o_ch_valid, o_frame_done, o_frame_err, o_ch_id, o_ch_data, o_err_code);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (o_ch_valid != e.smp || o_frame_done != e.done || o_frame_err != e.err ||
                    o_ch_num != e.num || o_err_code != e.code ||
                    (e.smp && (o_ch_id != e.id || o_ch_data != e.data))) begin
                    miscompares++;
                    $display("FAIL pulse_event: got v=%0b id=%0d d=%h done=%0b num=%0d err=%0b code=%0d, required v=%0b id=%0d d=%h done=%0b num=%0d err=%0b code=%0d",
                             o_ch_valid, o_ch_id, o_ch_data, o_frame_done, o_ch_num, o_frame_err, o_err_code,
                             e.smp, e.id, e.data, e.done, e.num, e.err, e.code);
                end
            end
        end
    end

    initial begin
        int cyc;
        vectors     = 0;
        miscompares = 0;
        m_num       = 0;
        m_code      = 0;
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-channel frame, back-to-back
        seg = '{'h55, 'h05, 'h18, 'h01, 'hAA, 'hAA, 'h02, 'h12, 'h34, 'h03, 'h56, 'h78,
                'h04, 'h9A, 'hBC, 'h05, 'hDE, 'hF0, 'h06, 'h0F, 'h0F, 'h07, 'h80, 'h01,
                'h08, 'hFF, 'hFF};
        run_seg();
        chk("t1_last_valid", int'(o_ch_valid), 1);
        chk("t1_last_id",    int'(o_ch_id), 8);
        chk("t1_last_data",  int'(o_ch_data), 'hFFFF);
        chk("t1_done",       int'(o_frame_done), 1);
        chk("t1_ch_num",     int'(o_ch_num), 8);
        chk("t1_err_code",   int'(o_err_code), 0);

        // noise then a 2-channel frame, directly following
        seg = '{'h00, 'h13, 'h55, 'h05, 'h06, 'h01, 'h01, 'h02, 'h02, 'h03, 'h04};
        run_seg();
        chk("t2_data", int'(o_ch_data), 'h0304);
        chk("t2_ch_num", int'(o_ch_num), 2);
        repeat (3) @(negedge clk);
        wait_drain("t2");

        // bad command, then a good 1-channel frame
        seg = '{'h55, 'h07, 'h06, 'h01, 'h11, 'h22, 'h55, 'h05, 'h03, 'h01, 'hBE, 'hEF};
        run_seg();
        chk("t3_ch_num", int'(o_ch_num), 1);
        chk("t3_code_held", int'(o_err_code), 1);
        repeat (3) @(negedge clk);
        wait_drain("t3");

        // bad lengths: 7 and 27
        seg = '{'h55, 'h05, 'h07, 'h55, 'h05, 'h1B};
        run_seg();
        chk("t4_err", int'(o_frame_err), 1);
        chk("t4_code", int'(o_err_code), 2);
        repeat (3) @(negedge clk);
        wait_drain("t4");

        // channel sequence error after one sample
        seg = '{'h55, 'h05, 'h06, 'h01, 'hAA, 'hBB, 'h03};
        run_seg();
        chk("t5_code", int'(o_err_code), 3);
        chk("t5_ch_num_held", int'(o_ch_num), 1);
        repeat (3) @(negedge clk);
        wait_drain("t5");

        // gap timeout after the high byte
        seg = '{'h55, 'h05, 'h06, 'h01, 'h12, TIMEOUT};
        run_seg();
        cyc = 0;
        while (cyc < int'(GAP) + 50) begin
            @(posedge clk);
            cyc++;
            #1;
            if (o_frame_err) break;
        end
        chk("t6_gap_latency", cyc, int'(GAP) + 1);
        @(negedge clk);
        chk("t6_code", int'(o_err_code), 4);
        wait_drain("t6");

        // reset mid-frame after one sample
        seg = '{'h55, 'h05, 'h06, 'h01, 'hAA, 'hBB, 'h02};
        run_seg();
        repeat (2) @(negedge clk);
        wait_drain("t7");
        rst_n  = 1'b0;
        m_num  = 0;
        m_code = 0;
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_zero("postreset");

        // a fresh frame parses cleanly after reset
        seg = '{'h55, 'h05, 'h03, 'h01, 'hCA, 'hFE};
        run_seg();
        chk("t8_data", int'(o_ch_data), 'hCAFE);
        chk("t8_ch_num", int'(o_ch_num), 1);
        repeat (3) @(negedge clk);
        wait_drain("t8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
